// File: rtl/thor2022_burst_sram.sv
// 128-bit Wishbone scratchpad responder with classic and linear/wrap burst access.
// Optional write protection: define THOR2022_SRAM_WP_EN to add the wp_i input.
module thor2022_burst_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'hFFF8_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cs_i,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic         we_i,
    input  logic [15:0]  sel_i,
    input  logic [31:0]  adr_i,
    input  logic [127:0] dat_i,
    input  logic [2:0]   cti_i,
    input  logic [1:0]   bte_i,
`ifdef THOR2022_SRAM_WP_EN
    input  logic         wp_i,
`endif
    output logic         ack_o,
    output logic         err_o,
    output logic         bok_o,
    output logic [127:0] dat_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, DRAIN} state_t;

    logic [127:0] r_mem [DEPTH];

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_ack;
    logic         r_err;
    logic         r_bok;
    logic [127:0] r_dat;
    logic [AW:0]  r_badr;

    logic         w_ack_nxt;
    logic         w_err_nxt;
    logic         w_bok_nxt;
    logic [AW:0]  w_badr_nxt;
    logic         w_mem_we;
    logic         w_mem_re;
    logic [AW-1:0] w_mem_idx;

    logic         w_sel;
    logic [27:0]  w_off;
    logic [AW-1:0] w_idx;
    logic         w_oor;
    logic         w_cti_ok;
    logic         w_beat_cti;
    logic         w_wp_blk;
    logic         w_unused_lo;

    assign w_sel       = cs_i & cyc_i & stb_i;
    assign w_off       = adr_i[31:4] - BASE[31:4];
    assign w_idx       = w_off[AW-1:0];
    assign w_oor       = |w_off[27:AW];
    assign w_beat_cti  = (cti_i == CTI_INCR) || (cti_i == CTI_END);
    assign w_cti_ok    = (cti_i == CTI_CLASSIC) || w_beat_cti;
    assign w_unused_lo = &{1'b0, adr_i[3:0]};

`ifdef THOR2022_SRAM_WP_EN
    assign w_wp_blk = we_i & wp_i;
`else
    assign w_wp_blk = 1'b0;
`endif

    // Wrap-N keeps the upper index bits and lets only the low log2(N) bits roll over.
    function automatic logic [AW:0] f_next(input logic [AW:0] idx, input logic [1:0] bte);
        logic [AW:0] inc;
        inc = idx + 1'b1;
        case (bte)
            2'b00:   f_next = inc;
            2'b01:   f_next = {idx[AW:2], inc[1:0]};
            2'b10:   f_next = {idx[AW:3], inc[2:0]};
            default: f_next = {idx[AW:4], inc[3:0]};
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_bok_nxt   = r_bok;
        w_badr_nxt  = r_badr;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_idx   = w_idx;

        case (r_state)
            IDLE: begin
                w_bok_nxt = 1'b0;
                if (w_sel) begin
                    if (w_oor || !w_cti_ok || w_wp_blk) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_mem_we  = we_i;
                        w_mem_re  = !we_i;
                        w_ack_nxt = 1'b1;
                        if (cti_i == CTI_INCR) begin
                            w_bok_nxt   = 1'b1;
                            w_badr_nxt  = f_next({1'b0, w_idx}, bte_i);
                            w_state_nxt = BURST;
                        end else begin
                            w_state_nxt = SINGLE;
                        end
                    end
                end
            end

            SINGLE: w_state_nxt = DRAIN;

            BURST: begin
                w_mem_idx = r_badr[AW-1:0];
                if (!cyc_i) begin
                    w_bok_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_sel) begin
                    // Top bit of the burst address set means a linear burst ran past DEPTH.
                    if (w_beat_cti && !r_badr[AW] && !w_wp_blk) begin
                        w_mem_we   = we_i;
                        w_mem_re   = !we_i;
                        w_ack_nxt  = 1'b1;
                        w_badr_nxt = f_next(r_badr, bte_i);
                        if (cti_i == CTI_END) w_state_nxt = DRAIN;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_bok_nxt   = 1'b0;
                        w_state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                w_bok_nxt = 1'b0;
                if (!stb_i || !cyc_i) w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_bok   <= 1'b0;
            r_dat   <= '0;
            r_badr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_bok   <= w_bok_nxt;
            r_dat   <= w_mem_re ? r_mem[w_mem_idx] : '0;
            r_badr  <= w_badr_nxt;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 16; i++) begin
                if (sel_i[i]) r_mem[w_mem_idx][8*i +: 8] <= dat_i[8*i +: 8];
            end
        end
    end

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign bok_o = r_bok;
    assign dat_o = r_dat;

endmodule

// File: doc/thor2022_burst_sram.md
Name: thor2022_burst_sram

Overview:
- 128-bit Wishbone responder (target) for the CPU's initiator bus port, sitting beside the interrupt controller and interval timer on the registered MPU bus.
- Provides on-chip scratchpad RAM with single-cycle classic reads and writes.
- Supports incrementing bursts (cti 3'b010) with linear or wrap-4/8/16 addressing, so cache-line fills run at one beat per clock.
- Returns err_o for out-of-range accesses and illegal burst types.

Parameters:
- DEPTH, 1024, number of 128-bit words (power of two).
- BASE, 32'hFFF80000, byte base address, aligned to DEPTH*16.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cs_i  in  1  region select from the address decoder.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  write enable.
- sel_i  in  16  byte lane enables.
- adr_i  in  32  byte address; bits [3:0] are ignored.
- dat_i  in  128  write data.
- cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- ack_o  out  1  beat acknowledge.
- err_o  out  1  error terminate.
- bok_o  out  1  burst accepted for current cycle.
- dat_o  out  128  read data; zero when not acknowledging, so it can be OR-merged on the read bus.

Behaviour:
- Reset: ack_o=0, err_o=0, bok_o=0, dat_o=0, state=IDLE, burst address=0. RAM contents are not reset.
- sel = cs_i & cyc_i & stb_i.
- Word index = (adr_i - BASE) >> 4.
- Out of range: the index is at or beyond DEPTH.
- States are IDLE, SINGLE, BURST, DRAIN.
- IDLE:
  - on sel with an out-of-range address, or with cti_i not in {000,010,111}: err_o=1 for one cycle, then go to DRAIN.
  - on sel with cti_i 000 or 111: perform the access and go to SINGLE.
  - on sel with cti_i 010: perform beat 0, load burst address = index+1 (wrapped per bte_i), set bok_o=1, and go to BURST.
- Access timing:
  - a write updates the RAM lanes where sel_i is set, on the same edge that raises ack_o.
  - a read registers RAM[index] into dat_o on the same edge that raises ack_o.
  - latency is therefore 1 cycle from strobe to ack.
- SINGLE: ack_o=1 for exactly one cycle, then ack_o=0, dat_o=0, and go to DRAIN.
- BURST:
  - ack_o stays high every cycle while sel holds and cti_i==010.
  - each acked beat accesses the burst address register, not adr_i, then advances it.
  - stb_i low while cyc_i is high is a wait state: ack_o=0, and the address is held.
  - cti_i==111 on an acked beat: this is the final beat; go to DRAIN next.
  - cyc_i dropping mid-burst: abort immediately; ack_o=0, bok_o=0, go to IDLE.
  - a burst that crosses DEPTH in linear mode raises err_o on the offending beat and goes to DRAIN.
- DRAIN: ack_o=0, err_o=0, bok_o=0; wait until stb_i=0 or cyc_i=0, then go to IDLE. This prevents a double ack while the master's registered strobe is still high.
- Wrap arithmetic:
  - wrap-N keeps the upper index bits; the low log2(N) bits increment modulo N.
  - linear increments the full index.
- ack_o and err_o are never asserted together.
- A write and a read never occur in the same cycle.

Optional Feature:
THOR2022_SRAM_WP_EN:
- When defined, adds a 1-bit input wp_i.
- Any write (single or burst beat) while wp_i=1:
  - the RAM is not modified;
  - err_o is raised instead of ack_o;
  - the cycle proceeds to DRAIN.
- Reads are unaffected by wp_i.
- When not defined, wp_i does not exist and all writes are accepted.

Test Plan:
- Classic write then read: write 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with sel 16'hFFFF to BASE+0x20, then read BASE+0x20 → ack_o 1 cycle after stb each time; read data matches; dat_o=0 the cycle after ack.
- Byte lanes: write sel 16'h00F0 with data 128'hAA.. over a location pre-written with all zeros → readback shows only bytes [7:4]=AA; all other bytes are 0.
- Linear burst: 4 beats from BASE+0x100 (cti 010,010,010,111; bte 00) → ack_o high for 4 consecutive cycles; data comes from words 0x10..0x13; ack_o=0 in the following cycle.
- Wrap-4 burst: start at BASE+0x130 (word 0x13) → beats read words 0x13, 0x10, 0x11, 0x12.
- Errors and abort:
  - access to BASE+DEPTH*16 → err_o for 1 cycle, no ack, RAM unchanged.
  - burst with cyc_i dropped after beat 2 → ack_o=0 on the next cycle; state IDLE; a following classic read acks normally.
- Reset mid-burst: assert rst_i asynchronously during beat 1 → ack_o, err_o, bok_o and dat_o go to 0 immediately; after release, a new classic access completes with 1-cycle latency.
